// File: rtl/store_buffer.sv
// In-order store buffer in front of a single-port data memory: loads get the port first, stores drain in idle cycles.
// Optional build macro STORE_FWD_EN enables store-to-load forwarding from the youngest overlapping entry.
module store_buffer #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         st_valid_i,
   input  logic [ADDRESS_WIDTH-1:0]     st_addr_i,
   input  logic [DATA_WIDTH-1:0]        st_data_i,
   input  logic [2:0]                   st_funct3_i,
   output logic                         st_ready_o,
   input  logic                         ld_valid_i,
   input  logic [ADDRESS_WIDTH-1:0]     ld_addr_i,
   input  logic [2:0]                   ld_funct3_i,
   output logic [DATA_WIDTH-1:0]        ld_data_o,
   output logic                         ld_stall_o,
   output logic                         mem_wr_en_o,
   output logic [2:0]                   mem_funct3_o,
   output logic [ADDRESS_WIDTH-1:0]     mem_addr_o,
   output logic [DATA_WIDTH-1:0]        mem_data_o,
   input  logic [DATA_WIDTH-1:0]        mem_rdata_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [2:0] F3_WORD = 3'b010;

   logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
   logic [DATA_WIDTH-1:0]    data_q [DEPTH];
   logic [2:0]               f3_q   [DEPTH];

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop, hit, serve;
`ifdef STORE_FWD_EN
   logic [PTR_W-1:0]      young_idx;
   logic                  fwd;
   logic [DATA_WIDTH-1:0] fwd_data;
`endif

   // Word-granular overlap scan, oldest to youngest, so the last match is the youngest.
   always_comb begin
      hit = 1'b0;
`ifdef STORE_FWD_EN
      young_idx = head_q;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         if ((CNT_W'(k) < count_q) &&
             (addr_q[head_q + PTR_W'(k)][ADDRESS_WIDTH-1:2] == ld_addr_i[ADDRESS_WIDTH-1:2])) begin
            hit = 1'b1;
`ifdef STORE_FWD_EN
            young_idx = head_q + PTR_W'(k);
`endif
         end
      end
   end

`ifdef STORE_FWD_EN
   always_comb begin
      fwd      = 1'b0;
      fwd_data = data_q[young_idx];
      if (hit && (f3_q[young_idx] == F3_WORD)) begin
         fwd = 1'b1;
         if (ld_funct3_i != F3_WORD)
            fwd_data = {{(DATA_WIDTH-8){1'b0}}, data_q[young_idx][{ld_addr_i[1:0], 3'b000} +: 8]};
      end else if (hit && (ld_funct3_i != F3_WORD) && (addr_q[young_idx] == ld_addr_i)) begin
         fwd      = 1'b1;
         fwd_data = {{(DATA_WIDTH-8){1'b0}}, data_q[young_idx][7:0]};
      end
   end

   assign ld_stall_o = ld_valid_i && hit && !fwd;
   assign ld_data_o  = (ld_valid_i && fwd) ? fwd_data : mem_rdata_i;
`else
   assign ld_stall_o = ld_valid_i && hit;
   assign ld_data_o  = mem_rdata_i;
`endif

   // Any hit (stalled or forwarded) leaves the port free for draining.
   assign serve        = ld_valid_i && !hit;
   assign mem_wr_en_o  = !serve && (count_q != '0);
   assign mem_addr_o   = serve ? ld_addr_i : addr_q[head_q];
   assign mem_funct3_o = serve ? ld_funct3_i : f3_q[head_q];
   assign mem_data_o   = data_q[head_q];

   assign st_ready_o = (count_q != CNT_W'(DEPTH));
   assign push       = st_valid_i && st_ready_o;
   assign pop        = mem_wr_en_o;
   assign count_o    = count_q;
   assign empty_o    = (count_q == '0);

   always_comb begin
      head_d  = pop  ? head_q + PTR_W'(1) : head_q;
      tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + CNT_W'(1);
      else if (pop && !push)
         count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry payload needs no reset; validity comes solely from head/count.
   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_q[tail_q] <= st_addr_i;
         data_q[tail_q] <= st_data_i;
         f3_q[tail_q]   <= st_funct3_i;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small byte/word data memory model on the memory port.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_valid;
   logic [31:0] st_addr, st_data;
   logic [2:0]  st_f3;
   logic        st_ready;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [2:0]  ld_f3;
   logic [31:0] ld_data;
   logic        ld_stall;
   logic        mem_wr_en;
   logic [2:0]  mem_f3;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  count;
   logic        empty;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   store_buffer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data), .st_funct3_i(st_f3),
      .st_ready_o(st_ready),
      .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_funct3_i(ld_f3),
      .ld_data_o(ld_data), .ld_stall_o(ld_stall),
      .mem_wr_en_o(mem_wr_en), .mem_funct3_o(mem_f3), .mem_addr_o(mem_addr),
      .mem_data_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .count_o(count), .empty_o(empty)
   );

   // Data memory model: combinational read, clocked write, LB zero-extended.
   logic [31:0] mem [0:255] = '{default: 32'h0};
   logic [31:0] mem_word;
   always_comb begin
      mem_word  = mem[mem_addr[9:2]];
      mem_rdata = (mem_f3 == 3'b010) ? mem_word : {24'h0, mem_word[{mem_addr[1:0], 3'b000} +: 8]};
   end
   always @(posedge clk) begin
      if (!rst_n)
         mem[8'h40] <= 32'h5A5A5A5A;
      else if (mem_wr_en) begin
         if (mem_f3 == 3'b010) mem[mem_addr[9:2]] <= mem_wdata;
         else                  mem[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_f3 = 3'b010;
      ld_valid = 1'b0; ld_addr = '0; ld_f3 = 3'b010;
      #12;
      chk("rst_st_ready", 32'(st_ready), 1);
      chk("rst_ld_stall", 32'(ld_stall), 0);
      chk("rst_wr_en",    32'(mem_wr_en), 0);
      chk("rst_count",    32'(count), 0);
      chk("rst_empty",    32'(empty), 1);
      #2 rst_n = 1'b1;
      cyc();

      // Single SW drains the cycle after it is pushed.
      st_valid = 1'b1; st_addr = 32'h10000; st_data = 32'hDEADBEEF; st_f3 = 3'b010;
      #1 chk("t1_no_drain_empty", 32'(mem_wr_en), 0);
      cyc();
      st_valid = 1'b0;
      #1;
      chk("t1_wr_en", 32'(mem_wr_en), 1);
      chk("t1_addr",  mem_addr, 32'h10000);
      chk("t1_data",  mem_wdata, 32'hDEADBEEF);
      chk("t1_f3",    32'(mem_f3), 32'h2);
      chk("t1_count1", 32'(count), 1);
      cyc();
      chk("t1_count0", 32'(count), 0);
      chk("t1_empty",  32'(empty), 1);
      chk("t1_mem",    mem[0], 32'hDEADBEEF);

      // Continuous non-hitting load blocks draining; buffer fills and refuses the 5th store.
      ld_valid = 1'b1; ld_addr = 32'h10100; ld_f3 = 3'b010;
      for (int i = 0; i < 5; i++) begin
         st_valid = 1'b1; st_addr = 32'h10000 + 32'(4*i); st_data = 32'hA0 + 32'(i); st_f3 = 3'b010;
         #1;
         chk("t2_ready",  32'(st_ready), (i < 4) ? 32'd1 : 32'd0);
         chk("t2_wr_en",  32'(mem_wr_en), 0);
         chk("t2_ldata",  ld_data, 32'h5A5A5A5A);
         chk("t2_stall",  32'(ld_stall), 0);
         cyc();
         chk("t2_count",  32'(count), (i < 4) ? 32'(i+1) : 32'd4);
      end
      st_valid = 1'b0; ld_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t2_drain_en",   32'(mem_wr_en), 1);
         chk("t2_drain_addr", mem_addr, 32'h10000 + 32'(4*k));
         chk("t2_drain_data", mem_wdata, 32'hA0 + 32'(k));
         cyc();
      end
      chk("t2_count_end", 32'(count), 0);

      // Overlap hazard on SW 0x10004.
      st_valid = 1'b1; st_addr = 32'h10004; st_data = 32'h11223344; st_f3 = 3'b010;
      cyc();
      st_valid = 1'b0;
`ifndef STORE_FWD_EN
      ld_valid = 1'b1; ld_addr = 32'h10004; ld_f3 = 3'b010;
      #1;
      chk("t3_stall",  32'(ld_stall), 1);
      chk("t3_wr_en",  32'(mem_wr_en), 1);
      chk("t3_waddr",  mem_addr, 32'h10004);
      cyc();
      chk("t3_stall_drop", 32'(ld_stall), 0);
      chk("t3_ldata",      ld_data, 32'h11223344);
      ld_addr = 32'h10006; ld_f3 = 3'b000;
      #1 chk("t3_lb", ld_data, 32'h00000022);
      // SB to a different byte of the same word still stalls an LB.
      ld_valid = 1'b0;
      st_valid = 1'b1; st_addr = 32'h10005; st_data = 32'hFFFFFF99; st_f3 = 3'b000;
      cyc();
      st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h10006; ld_f3 = 3'b000;
      #1 chk("t3_sb_stall", 32'(ld_stall), 1);
      cyc();
      ld_addr = 32'h10005;
      #1;
      chk("t3_sb_nostall", 32'(ld_stall), 0);
      chk("t3_sb_ldata",   ld_data, 32'h00000099);
      chk("t3_sb_word",    mem[1], 32'h11229944);
`else
      ld_valid = 1'b1; ld_addr = 32'h10006; ld_f3 = 3'b000;
      #1;
      chk("t3f_stall",  32'(ld_stall), 0);
      chk("t3f_ldata",  ld_data, 32'h00000022);
      chk("t3f_wr_en",  32'(mem_wr_en), 1);
      ld_valid = 1'b0;
      cyc();
      st_valid = 1'b1; st_addr = 32'h10004; st_data = 32'h00000077; st_f3 = 3'b000;
      cyc();
      st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h10004; ld_f3 = 3'b010;
      #1 chk("t3f_sb_lw_stall", 32'(ld_stall), 1);
      cyc();
      chk("t3f_sb_lw_nostall", 32'(ld_stall), 0);
      chk("t3f_sb_lw_ldata",   ld_data, 32'h11223377);
`endif
      ld_valid = 1'b0;
      cyc();
      chk("t3_count_end", 32'(count), 0);

      // Push every cycle at count 1: count holds and order survives pointer wrap.
      st_valid = 1'b1; st_addr = 32'h10020; st_data = 32'hC0; st_f3 = 3'b010;
      cyc();
      for (int i = 1; i <= 6; i++) begin
         st_addr = 32'h10020 + 32'(4*i); st_data = 32'hC0 + 32'(i);
         #1;
         chk("t4_wr_en",  32'(mem_wr_en), 1);
         chk("t4_addr",   mem_addr, 32'h10020 + 32'(4*(i-1)));
         chk("t4_data",   mem_wdata, 32'hC0 + 32'(i-1));
         cyc();
         chk("t4_count",  32'(count), 1);
      end
      st_valid = 1'b0;
      #1 chk("t4_last_addr", mem_addr, 32'h10038);
      cyc();
      chk("t4_count_end", 32'(count), 0);

      // Same-cycle store is younger than the load and not hazard-checked.
      ld_valid = 1'b1; ld_addr = 32'h10100; ld_f3 = 3'b010;
      st_valid = 1'b1; st_addr = 32'h10100; st_data = 32'h00000001; st_f3 = 3'b010;
      #1;
      chk("t5_same_stall", 32'(ld_stall), 0);
      chk("t5_same_ldata", ld_data, 32'h5A5A5A5A);
      cyc();
      st_valid = 1'b0;
`ifndef STORE_FWD_EN
      #1 chk("t5_next_stall", 32'(ld_stall), 1);
      cyc();
`endif
      #1;
      chk("t5_after_stall", 32'(ld_stall), 0);
      chk("t5_after_ldata", ld_data, 32'h00000001);
      ld_valid = 1'b0;
      cyc();

      // Asynchronous reset with three buffered stores.
      ld_valid = 1'b1; ld_addr = 32'h10100; ld_f3 = 3'b010;
      for (int i = 0; i < 3; i++) begin
         st_valid = 1'b1; st_addr = 32'h10040 + 32'(4*i); st_data = 32'hE0 + 32'(i); st_f3 = 3'b010;
         cyc();
      end
      st_valid = 1'b0; ld_valid = 1'b0;
      #1;
      chk("t6_count3", 32'(count), 3);
      chk("t6_wr_en",  32'(mem_wr_en), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_wr_en", 32'(mem_wr_en), 0);
      chk("t6_rst_count", 32'(count), 0);
      chk("t6_rst_empty", 32'(empty), 1);
      chk("t6_rst_ready", 32'(st_ready), 1);
      #2 rst_n = 1'b1;
      cyc();
      chk("t6_post_wr_en", 32'(mem_wr_en), 0);
      cyc();
      chk("t6_post_wr_en2", 32'(mem_wr_en), 0);
      chk("t6_post_count",  32'(count), 0);
      chk("t6_no_stale",    mem[8'h10], 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small in-order FIFO of pending stores between the memory-access pipeline stage and data_memory.
- Retires stores to the memory's single combinational-read / clocked-write port in idle cycles, so loads get port priority.
- Loads go through combinationally; any pending store that overlaps the load's word stalls the load until that store has drained.

Parameters:
- ADDRESS_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- DEPTH, 4, number of buffered stores; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- st_valid_i  in  1  store request from pipeline.
- st_addr_i  in  ADDRESS_WIDTH  store byte address.
- st_data_i  in  DATA_WIDTH  store data; SB uses [7:0].
- st_funct3_i  in  3  010 = SW; any other value = SB.
- st_ready_o  out  1  buffer can accept a store this cycle.
- ld_valid_i  in  1  load request.
- ld_addr_i  in  ADDRESS_WIDTH  load byte address.
- ld_funct3_i  in  3  010 = LW; any other value = LB (zero-extended).
- ld_data_o  out  DATA_WIDTH  load result, same cycle.
- ld_stall_o  out  1  load cannot complete this cycle; pipeline holds the load.
- mem_wr_en_o  out  1  to data_memory wr_en_i.
- mem_funct3_o  out  3  to data_memory funct3_i.
- mem_addr_o  out  ADDRESS_WIDTH  to data_memory addr_i.
- mem_data_o  out  DATA_WIDTH  to data_memory data_i.
- mem_rdata_i  in  DATA_WIDTH  from data_memory data_o.
- count_o  out  $clog2(DEPTH+1)  occupied entries.
- empty_o  out  1  count_o == 0.

Behaviour:
- Storage and pointers:
  - Entries hold {addr, data, funct3}.
  - Head/tail pointers wrap modulo DEPTH.
  - Count register, 0..DEPTH.
- Reset (asynchronous, rst_ni low):
  - Pointers and count cleared; buffered stores discarded.
  - Outputs immediately: st_ready_o=1, ld_stall_o=0, mem_wr_en_o=0, count_o=0, empty_o=1.
  - Reset mid-drain aborts the write: mem_wr_en_o drops before the next edge.
- Push:
  - st_ready_o = (count != DEPTH); purely registered state, no same-cycle pop credit.
  - st_valid_i && st_ready_o writes the tail entry at the edge.
- Hazard (combinational, registered entries only):
  - hit = any valid entry with addr[ADDRESS_WIDTH-1:2] == ld_addr_i[ADDRESS_WIDTH-1:2].
  - ld_stall_o = ld_valid_i && hit (modified by the optional feature below).
- Port arbitration, each cycle:
  - Serve load: ld_valid_i && !ld_stall_o.
    - mem_addr_o=ld_addr_i, mem_funct3_o=ld_funct3_i, mem_wr_en_o=0.
    - ld_data_o=mem_rdata_i, zero-cycle latency.
  - Drain: otherwise, if count>0.
    - mem_addr_o/mem_data_o/mem_funct3_o come from the head entry; mem_wr_en_o=1.
    - Head pops at the edge.
    - A stalled load therefore always lets the buffer drain; the stall drops in the cycle after the last hitting entry pops.
  - Idle: mem_wr_en_o=0; ld_data_o=mem_rdata_i.
- Ordering:
  - A load and a store presented in the same cycle: the load is older.
  - The same-cycle store is not checked for hazard against that load.
- Count update:
  - Push and pop in the same edge: count unchanged, entries stay in FIFO order.
  - Full: push refused; a pop that cycle frees a slot for the next cycle.
- Drain fairness: continuous non-hitting loads starve draining. This is accepted; the pipeline guarantees gaps.

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined:
  - On hit, only the youngest matching entry is examined.
  - If it is SW: forward, ld_stall_o=0, no memory access.
    - LW returns the entry data.
    - LB returns {24'b0, data[8*ld_addr_i[1:0] +: 8]}.
  - If it is SB, the load is LB and the full byte address is equal: forward {24'b0, data[7:0]}.
  - Otherwise stall as in the base behaviour.
  - A forwarding cycle is not a load-serve cycle, so draining continues in that cycle.
- Undefined: any hit stalls; no forwarding logic.

Test Plan:
- Reset, push SW 0x10000 / 0xDEADBEEF, no loads → next cycle: mem_wr_en_o=1, mem_addr_o=0x10000, mem_data_o=0xDEADBEEF, mem_funct3_o=010; after the edge count_o=0, empty_o=1.
- Hold LW 0x10100 valid with memory returning 0x5A5A5A5A; push 5 stores to 0x10000..0x10010 → count_o reaches 4, st_ready_o=0, 5th store refused, mem_wr_en_o=0 throughout, ld_data_o=0x5A5A5A5A.
- Base build: buffer holds SW 0x10004 / 0x11223344; issue LW 0x10004 → ld_stall_o=1 for one cycle while the entry drains; next cycle ld_stall_o=0, ld_data_o=0x11223344.
- STORE_FWD_EN build: same entry, LB 0x10006 → ld_stall_o=0, ld_data_o=0x00000022, mem_wr_en_o=1 (drain proceeds). SB 0x10004 followed by LW 0x10004 → stall.
- Count 1, push every cycle with no loads for 6 cycles → count_o stays 1; stores emerge on the memory port in push order across pointer wrap.
- Buffer holds 3 entries, drop rst_ni mid-cycle → mem_wr_en_o=0 and count_o=0 before the next edge; after release no stale write appears.
